// File: rtl/aui_tx_scheduler.sv
// aui_tx_scheduler: paces 257b block acceptance into 80-block AM-mapped frames,
// opens an AM insertion slot every P frames, and qualifies link-up from the
// 16 lane sync flags.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | not running; am period is latched when i_enable rises
// RUN      | accepting blocks; frame ends may open an AM slot
// AM_SLOT  | source stalled for AM_STALL cycles while AM is inserted
// DRAIN    | run request withdrawn; finish the current frame, then idle
module aui_tx_scheduler #(
    parameter int BLOCKS_PER_FRAME = 80,
    parameter int AM_STALL         = 4,
    parameter int LOCK_CYCLES      = 16,
    parameter int CNT_W            = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_enable,
    input  logic [CNT_W-1:0] i_am_period,
    input  logic             i_src_valid,
    output logic             o_src_ready,
    output logic             o_dist_valid,
    output logic             o_frame_start,
    output logic             o_am_insert,
    output logic [6:0]       o_block_idx,
    output logic [CNT_W-1:0] o_frame_cnt,
    input  logic [15:0]      i_sync_lanes,
    output logic             o_link_up,
    output logic [7:0]       o_sync_loss,
    output logic [1:0]       o_state
);

    localparam int              AM_W     = (AM_STALL > 1) ? $clog2(AM_STALL) : 1;
    localparam int              LOCK_W   = $clog2(LOCK_CYCLES + 1);
    localparam logic [6:0]      BLK_LAST = 7'(BLOCKS_PER_FRAME - 1);
    localparam logic [AM_W-1:0] AM_LAST  = AM_W'(AM_STALL - 1);
    localparam logic [LOCK_W-1:0] LOCK_FULL = LOCK_W'(LOCK_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_AM_SLOT = 2'd2,
        ST_DRAIN   = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [6:0]        blk_q, blk_d;
    logic [CNT_W-1:0]  frame_cnt_q, frame_cnt_d;
    logic [CNT_W-1:0]  period_q, period_d;
    logic [AM_W-1:0]   am_cnt_q, am_cnt_d;
    logic              am_insert_q, am_insert_d;
    logic              dist_valid_q;
    logic              frame_start_q;
    logic [6:0]        block_idx_q;
    logic [LOCK_W-1:0] lock_cnt_q, lock_cnt_d;
    logic [7:0]        sync_loss_q, sync_loss_d;

    logic              accept;
    logic              frame_end;
    logic [CNT_W-1:0]  frame_cnt_inc;
    logic              am_due;
    logic              all_sync;

    assign o_src_ready   = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign accept        = i_src_valid & o_src_ready;
    assign frame_end     = accept && (blk_q == BLK_LAST);
    assign frame_cnt_inc = frame_cnt_q + CNT_W'(1);
    assign am_due        = (frame_cnt_inc == period_q);
    assign all_sync      = &i_sync_lanes;

    // Next-state and frame/block counter updates.
    always_comb begin
        state_d     = state_q;
        blk_d       = blk_q;
        frame_cnt_d = frame_cnt_q;
        period_d    = period_q;
        am_cnt_d    = am_cnt_q;
        am_insert_d = 1'b0;

        if (accept) begin
            blk_d = frame_end ? 7'd0 : blk_q + 7'd1;
        end
        if (frame_end) begin
            frame_cnt_d = frame_cnt_inc;
        end

        case (state_q)
            ST_IDLE: begin
                if (i_enable) begin
                    period_d    = (i_am_period == '0) ? CNT_W'(1) : i_am_period;
                    frame_cnt_d = '0;
                    blk_d       = 7'd0;
                    state_d     = ST_RUN;
                end
            end
            ST_RUN, ST_DRAIN: begin
                if (frame_end) begin
                    // AM slot takes priority over stopping so the marker cadence is kept.
                    if (am_due) begin
                        state_d     = ST_AM_SLOT;
                        frame_cnt_d = '0;
                        am_cnt_d    = AM_LAST;
                        am_insert_d = 1'b1;
                    end else if ((state_q == ST_DRAIN) || !i_enable) begin
                        state_d = ST_IDLE;
                    end
                end else if (!i_enable) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_AM_SLOT: begin
                if (am_cnt_q == '0) begin
                    state_d = i_enable ? ST_RUN : ST_IDLE;
                end else begin
                    am_cnt_d = am_cnt_q - AM_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Scheduler registers and the registered distributor strobe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            blk_q         <= 7'd0;
            frame_cnt_q   <= '0;
            period_q      <= '0;
            am_cnt_q      <= '0;
            am_insert_q   <= 1'b0;
            dist_valid_q  <= 1'b0;
            frame_start_q <= 1'b0;
            block_idx_q   <= 7'd0;
        end else begin
            state_q       <= state_d;
            blk_q         <= blk_d;
            frame_cnt_q   <= frame_cnt_d;
            period_q      <= period_d;
            am_cnt_q      <= am_cnt_d;
            am_insert_q   <= am_insert_d;
            dist_valid_q  <= accept;
            frame_start_q <= accept && (blk_q == 7'd0);
            if (accept) begin
                block_idx_q <= blk_q;
            end
        end
    end

    // Lock qualification and sync-loss bookkeeping.
    always_comb begin
        lock_cnt_d  = lock_cnt_q;
        sync_loss_d = sync_loss_q;
        if (all_sync) begin
            if (lock_cnt_q != LOCK_FULL) begin
                lock_cnt_d = lock_cnt_q + LOCK_W'(1);
            end
        end else begin
            lock_cnt_d = '0;
            if (o_link_up && (sync_loss_q != 8'hFF)) begin
                sync_loss_d = sync_loss_q + 8'd1;
            end
        end
    end

    // Link monitor registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lock_cnt_q  <= '0;
            sync_loss_q <= 8'd0;
        end else begin
            lock_cnt_q  <= lock_cnt_d;
            sync_loss_q <= sync_loss_d;
        end
    end

    assign o_link_up     = (lock_cnt_q == LOCK_FULL);
    assign o_sync_loss   = sync_loss_q;
    assign o_dist_valid  = dist_valid_q;
    assign o_frame_start = frame_start_q;
    assign o_am_insert   = am_insert_q;
    assign o_block_idx   = block_idx_q;
    assign o_frame_cnt   = frame_cnt_q;
    assign o_state       = state_q;

endmodule

// File: tb/tb_aui_tx_scheduler.sv
// Bench for aui_tx_scheduler: behavioural model compared every cycle, plus
// directed scenarios with hand-computed expectations.
module tb_aui_tx_scheduler;

    localparam int BPF   = 80;
    localparam int STALL = 4;
    localparam int LOCK  = 16;
    localparam int CW    = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          en = 1'b0;
    logic [CW-1:0] per = '0;
    logic          sv = 1'b0;
    logic [15:0]   sync = 16'h0000;
    logic          o_src_ready, o_dist_valid, o_frame_start, o_am_insert, o_link_up;
    logic [6:0]    o_block_idx;
    logic [CW-1:0] o_frame_cnt;
    logic [7:0]    o_sync_loss;
    logic [1:0]    o_state;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    aui_tx_scheduler #(
        .BLOCKS_PER_FRAME(BPF), .AM_STALL(STALL), .LOCK_CYCLES(LOCK), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst(rst), .i_enable(en), .i_am_period(per), .i_src_valid(sv),
        .o_src_ready(o_src_ready), .o_dist_valid(o_dist_valid), .o_frame_start(o_frame_start),
        .o_am_insert(o_am_insert), .o_block_idx(o_block_idx), .o_frame_cnt(o_frame_cnt),
        .i_sync_lanes(sync), .o_link_up(o_link_up), .o_sync_loss(o_sync_loss), .o_state(o_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: mode 0 idle, 1 run, 2 am slot, 3 drain.
    int m_st, m_blk, m_fcnt, m_p, m_am_left, m_idx, m_lock, m_loss;
    bit m_dv, m_fs, m_ami;

    task automatic m_reset();
        m_st = 0; m_blk = 0; m_fcnt = 0; m_p = 0; m_am_left = 0; m_idx = 0;
        m_lock = 0; m_loss = 0; m_dv = 0; m_fs = 0; m_ami = 0;
    endtask

    task automatic m_step();
        bit rdy, acc, fend;
        rdy  = (m_st == 1) || (m_st == 3);
        acc  = sv && rdy;
        fend = acc && (m_blk == BPF - 1);
        m_dv  = acc;
        m_fs  = acc && (m_blk == 0);
        m_ami = 0;
        if (acc) begin
            m_idx = m_blk;
            m_blk = (m_blk + 1) % BPF;
        end
        case (m_st)
            0: if (en) begin
                m_p = (per == 0) ? 1 : int'(per);
                m_fcnt = 0; m_blk = 0; m_st = 1;
            end
            1, 3: begin
                if (fend) begin
                    m_fcnt++;
                    if (m_fcnt == m_p) begin
                        m_fcnt = 0; m_st = 2; m_am_left = STALL; m_ami = 1;
                    end else if (m_st == 3 || !en) begin
                        m_st = 0;
                    end
                end else if (!en) begin
                    m_st = 3;
                end
            end
            default: begin
                m_am_left--;
                if (m_am_left == 0) m_st = en ? 1 : 0;
            end
        endcase
        if (sync == 16'hFFFF) begin
            if (m_lock < LOCK) m_lock++;
        end else begin
            if (m_lock == LOCK && m_loss < 255) m_loss++;
            m_lock = 0;
        end
    endtask

    // Model advances on the same edges as the DUT, including async reset.
    always @(posedge clk or negedge rst) begin
        if (!rst) m_reset();
        else m_step();
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("ready", int'(o_src_ready), int'(m_st == 1 || m_st == 3));
            check("dist_valid", int'(o_dist_valid), int'(m_dv));
            check("frame_start", int'(o_frame_start), int'(m_fs));
            check("am_insert", int'(o_am_insert), int'(m_ami));
            check("block_idx", int'(o_block_idx), m_idx);
            check("frame_cnt", int'(o_frame_cnt), m_fcnt);
            check("state", int'(o_state), m_st);
            check("link_up", int'(o_link_up), int'(m_lock == LOCK));
            check("sync_loss", int'(o_sync_loss), m_loss);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int dvc, fsc, lowc, first, last;
        bit found;

        // Reset state
        m_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", int'(o_src_ready), 0);
        check("rst_state", int'(o_state), 0);
        check("rst_dv", int'(o_dist_valid), 0);
        check("rst_link", int'(o_link_up), 0);
        check("rst_loss", int'(o_sync_loss), 0);
        rst = 1'b1;
        chk_en = 1'b1;

        // Link qualification
        tick();
        sync = 16'hFFFF;
        repeat (15) tick();
        check("link_after15", int'(o_link_up), 0);
        tick();
        check("link_after16", int'(o_link_up), 1);
        sync = 16'hFFFF & ~(16'h1 << 9);
        tick();
        check("link_drop", int'(o_link_up), 0);
        check("loss_one", int'(o_sync_loss), 1);
        sync = 16'hFFFF;
        repeat (15) tick();
        check("link_relock15", int'(o_link_up), 0);
        tick();
        check("link_relock16", int'(o_link_up), 1);

        // P=2, source always valid: two frames then AM slot
        en = 1'b1; per = 16'd2; sv = 1'b1;
        dvc = 0; fsc = 0; found = 0;
        for (int i = 0; i < 400; i++) begin
            tick();
            if (o_dist_valid) dvc++;
            if (o_frame_start) fsc++;
            if (o_am_insert) begin found = 1; break; end
        end
        check("am_seen", int'(found), 1);
        check("am_dv_count", dvc, 160);
        check("am_fs_count", fsc, 2);
        check("am_frame_cnt", int'(o_frame_cnt), 0);
        lowc = 0;
        for (int i = 0; i < 20; i++) begin
            if (o_src_ready) break;
            lowc++;
            tick();
        end
        check("am_stall_len", lowc, 4);

        // Enable drop at blk=10 -> drain 70 blocks then idle
        found = 0;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (o_dist_valid && o_block_idx == 7'd9) begin found = 1; break; end
        end
        check("drain_wait", int'(found), 1);
        en = 1'b0;
        dvc = 0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (o_dist_valid) dvc++;
        end
        check("drain_count", dvc, 70);
        check("drain_state", int'(o_state), 0);
        check("drain_ready", int'(o_src_ready), 0);

        // Toggling source: one accept every other cycle
        en = 1'b1; per = 16'd3;
        dvc = 0; first = 0; last = 0; found = 0;
        for (int i = 0; i < 400; i++) begin
            tick();
            sv = ~sv;
            if (o_dist_valid) begin
                dvc++;
                if (dvc == 1) first = i;
                if (dvc == 80) begin last = i; found = 1; break; end
            end
        end
        check("tog_seen", int'(found), 1);
        check("tog_last_idx", int'(o_block_idx), 79);
        check("tog_span", last - first, 158);
        check("tog_frame_cnt", int'(o_frame_cnt), 1);

        // Reset mid-run at blk=37, restart with period 0
        sv = 1'b1;
        found = 0;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (o_dist_valid && o_block_idx == 7'd36) begin found = 1; break; end
        end
        check("rst37_wait", int'(found), 1);
        #2 rst = 1'b0; per = '0;
        #1;
        check("rst37_ready", int'(o_src_ready), 0);
        check("rst37_dv", int'(o_dist_valid), 0);
        check("rst37_idx", int'(o_block_idx), 0);
        check("rst37_state", int'(o_state), 0);
        check("rst37_fcnt", int'(o_frame_cnt), 0);
        #2 rst = 1'b1;
        found = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (o_dist_valid) begin found = 1; break; end
        end
        check("restart_seen", int'(found), 1);
        check("restart_idx", int'(o_block_idx), 0);
        check("restart_fs", int'(o_frame_start), 1);
        dvc = 1; found = 0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (o_dist_valid) dvc++;
            if (o_am_insert) begin found = 1; break; end
        end
        check("p0_am_seen", int'(found), 1);
        check("p0_dv_count", dvc, 80);

        // Randomized run against the model
        for (int c = 0; c < 20000; c++) begin
            tick();
            en   = ($urandom_range(0, 63) != 0);
            sv   = ($urandom_range(0, 3) != 0);
            per  = CW'($urandom_range(0, 3));
            sync = ($urandom_range(0, 15) == 0) ? 16'($urandom) : 16'hFFFF;
            if (c % 2500 == 1234) begin
                #1 rst = 1'b0;
                #1 rst = 1'b1;
            end
        end

        tick();
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
